// File: rtl/mcu_nbit_core_if.sv
`default_nettype none
// ============================================================================
// Module      : mcu_nbit_core_if
// Description : Bus between the accumulator core and its surroundings:
//               run/hold control, the instruction-fetch path, and the
//               architectural status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcu_nbit_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int OPR_W  = 4
);
  logic              Run;
  logic [OPR_W+3:0]  Instr;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] Acc;
  logic              Halted;
  logic              Fault;

  // Environment side: instruction memory and run control.
  modport master (
    output Run, Instr,
    input  PC, Acc, Halted, Fault
  );

  // Core side.
  modport slave (
    input  Run, Instr,
    output PC, Acc, Halted, Fault
  );
endinterface
`default_nettype wire

// File: rtl/mcu_nbit_core.sv
`default_nettype none
// ============================================================================
// Module      : mcu_nbit_core
// Description : Parametrised accumulator micro-controller core. Two-cycle
//               FETCH/EXEC sequencing, register file, Z/C flags, hardware
//               return stack for CALL/RET, absorbing HALT and FAULT states.
//               Instruction memory is external and read combinationally at PC.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_nbit_core #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int OPR_W       = 4,
  parameter int NUM_REGS    = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input logic            Clk,
  input logic            Reset,
  mcu_nbit_core_if.slave bus
);

  localparam int c_ir_w   = OPR_W + 4;
  localparam int c_reg_aw = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int c_sp_w   = $clog2(STACK_DEPTH + 1);
  localparam int c_sa_w   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [PC_W-1:0]   c_pc_rst  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]   c_pc_one  = PC_W'(1);
  localparam logic [c_sp_w-1:0] c_sp_one  = c_sp_w'(1);
  localparam logic [c_sp_w-1:0] c_sp_full = c_sp_w'(STACK_DEPTH);

  localparam logic [3:0] c_op_ldi  = 4'h1;
  localparam logic [3:0] c_op_ldr  = 4'h2;
  localparam logic [3:0] c_op_str  = 4'h3;
  localparam logic [3:0] c_op_add  = 4'h4;
  localparam logic [3:0] c_op_sub  = 4'h5;
  localparam logic [3:0] c_op_and  = 4'h6;
  localparam logic [3:0] c_op_or   = 4'h7;
  localparam logic [3:0] c_op_xor  = 4'h8;
  localparam logic [3:0] c_op_jmp  = 4'h9;
  localparam logic [3:0] c_op_jz   = 4'hA;
  localparam logic [3:0] c_op_jc   = 4'hB;
  localparam logic [3:0] c_op_call = 4'hC;
  localparam logic [3:0] c_op_ret  = 4'hD;
  localparam logic [3:0] c_op_hlt  = 4'hE;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [c_ir_w-1:0]   r_ir, w_ir_nxt;
  logic [DATA_W-1:0]   r_acc, w_acc_nxt;
  logic                r_z, w_z_nxt;
  logic                r_c, w_c_nxt;
  logic [c_sp_w-1:0]   r_sp, w_sp_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [PC_W-1:0]     r_stack [STACK_DEPTH];

  logic                w_push;
  logic                w_reg_we;
  logic                w_alu;
  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_imm_d;
  logic [PC_W-1:0]     w_imm_p;
  logic [c_reg_aw-1:0] w_ridx;
  logic [DATA_W-1:0]   w_rval;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [c_sa_w-1:0]   w_push_idx;
  logic [c_sa_w-1:0]   w_pop_idx;
  logic [PC_W-1:0]     w_ret_pc;

  // With a single register there is no index field to decode.
  generate
    if (NUM_REGS > 1) begin : g_ridx_many
      assign w_ridx = r_ir[c_reg_aw-1:0];
    end else begin : g_ridx_one
      assign w_ridx = '0;
    end
  endgenerate

  assign w_op    = r_ir[c_ir_w-1:OPR_W];
  assign w_imm_d = DATA_W'(r_ir[OPR_W-1:0]);
  assign w_imm_p = PC_W'(r_ir[OPR_W-1:0]);
  assign w_rval  = r_regs[w_ridx];

  // One extra bit on the ALU results captures carry-out and borrow.
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_rval};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_rval};

  // Push writes the slot at SP; pop reads the slot just below it.
  assign w_push_idx = r_sp[c_sa_w-1:0];
  assign w_pop_idx  = c_sa_w'(r_sp - c_sp_one);
  assign w_ret_pc   = r_stack[w_pop_idx];

  // Next-state and datapath decode: FETCH latches IR, EXEC retires it.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_nxt   = r_acc;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    w_sp_nxt    = r_sp;
    w_push      = 1'b0;
    w_reg_we    = 1'b0;
    w_alu       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_nxt    = bus.Instr;
        w_pc_nxt    = r_pc + c_pc_one;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          c_op_ldi: w_acc_nxt = w_imm_d;
          c_op_ldr: w_acc_nxt = w_rval;
          c_op_str: w_reg_we  = 1'b1;
          c_op_add: begin
            {w_c_nxt, w_acc_nxt} = w_sum;
            w_alu                = 1'b1;
          end
          c_op_sub: begin
            {w_c_nxt, w_acc_nxt} = w_diff;
            w_alu                = 1'b1;
          end
          c_op_and: begin
            w_acc_nxt = r_acc & w_rval;
            w_c_nxt   = 1'b0;
            w_alu     = 1'b1;
          end
          c_op_or: begin
            w_acc_nxt = r_acc | w_rval;
            w_c_nxt   = 1'b0;
            w_alu     = 1'b1;
          end
          c_op_xor: begin
            w_acc_nxt = r_acc ^ w_rval;
            w_c_nxt   = 1'b0;
            w_alu     = 1'b1;
          end
          c_op_jmp: w_pc_nxt = w_imm_p;
          c_op_jz:  if (r_z) w_pc_nxt = w_imm_p;
          c_op_jc:  if (r_c) w_pc_nxt = w_imm_p;
          c_op_call: begin
            // A full stack faults without pushing; PC keeps the fetch increment.
            if (r_sp == c_sp_full) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + c_sp_one;
              w_pc_nxt = w_imm_p;
            end
          end
          c_op_ret: begin
            if (r_sp == '0) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_sp_nxt = r_sp - c_sp_one;
              w_pc_nxt = w_ret_pc;
            end
          end
          c_op_hlt: w_state_nxt = S_HALT;
          default: ;
        endcase
        if (w_alu) w_z_nxt = (w_acc_nxt == '0);
      end
      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Architectural state register: reset has priority, Run=0 freezes everything.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_FETCH;
      r_pc    <= c_pc_rst;
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_sp    <= '0;
    end else if (bus.Run) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_acc   <= w_acc_nxt;
      r_z     <= w_z_nxt;
      r_c     <= w_c_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Register file: cleared on reset, written by STR.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.Run && w_reg_we) begin
      r_regs[w_ridx] <= r_acc;
    end
  end

  // Return stack storage: contents need no reset, SP alone defines validity.
  always_ff @(posedge Clk) begin
    if (Reset && bus.Run && w_push) r_stack[w_push_idx] <= r_pc;
  end

  assign bus.PC     = r_pc;
  assign bus.Acc    = r_acc;
  assign bus.Halted = (r_state == S_HALT);
  assign bus.Fault  = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_mcu_nbit_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_nbit_core
// Description : Self-checking bench for mcu_nbit_core. Two instances: a narrow
//               one (DATA_W=8, PC_W=4, STACK_DEPTH=2) and a wide one
//               (DATA_W=16, NUM_REGS=8, RESET_PC=5). Expected snapshots of
//               {Halted, Fault, PC, Acc} are queued with the program, then
//               popped and compared as the core executes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_nbit_core;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, LDR = 4'h2, STR = 4'h3;
  localparam logic [3:0] ADD = 4'h4, SUB = 4'h5, AND = 4'h6, OR  = 4'h7;
  localparam logic [3:0] XOR = 4'h8, JMP = 4'h9, JZ  = 4'hA, JC  = 4'hB;
  localparam logic [3:0] CALL = 4'hC, RET = 4'hD, HLT = 4'hE;

  typedef struct {
    string       name;
    int          cyc;
    bit          run;
    bit          rst;
    logic [25:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [256];

  always #5 clk = ~clk;

  mcu_nbit_core_if #(.DATA_W(8), .PC_W(4), .OPR_W(4)) if_a ();
  mcu_nbit_core_if #(.DATA_W(16), .PC_W(8), .OPR_W(4)) if_b ();

  assign if_a.Instr = mem_a[if_a.PC];
  assign if_b.Instr = mem_b[if_b.PC];

  mcu_nbit_core #(
    .DATA_W(8), .PC_W(4), .OPR_W(4), .NUM_REGS(4), .STACK_DEPTH(2), .RESET_PC(0)
  ) dut_a (
    .Clk(clk), .Reset(rst_n), .bus(if_a)
  );

  mcu_nbit_core #(
    .DATA_W(16), .PC_W(8), .OPR_W(4), .NUM_REGS(8), .STACK_DEPTH(4), .RESET_PC(5)
  ) dut_b (
    .Clk(clk), .Reset(rst_n), .bus(if_b)
  );

  function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] opr);
    return {op, opr};
  endfunction

  function automatic logic [25:0] pk(input logic h, input logic f,
                                     input logic [7:0] pc, input logic [15:0] acc);
    return {h, f, pc, acc};
  endfunction

  function automatic logic [25:0] obs_a();
    return {if_a.Halted, if_a.Fault, 4'h0, if_a.PC, 8'h00, if_a.Acc};
  endfunction

  function automatic logic [25:0] obs_b();
    return {if_b.Halted, if_b.Fault, if_b.PC, if_b.Acc};
  endfunction

  task automatic push(input string n, input int cyc, input bit run, input bit rst,
                      input logic [25:0] exp);
    exp_t e;
    e.name = n; e.cyc = cyc; e.run = run; e.rst = rst; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++)  mem_a[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
  endtask

  // One reset edge; Run is held at run_v across it.
  task automatic do_reset(input bit run_v);
    @(negedge clk);
    rst_n = 1'b0;
    if_a.Run = run_v;
    if_b.Run = run_v;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    clear_mem();
    do_reset(1'b0);
    push("rst_b", 0, 1'b0, 1'b0, pk(0, 0, 8'd5, 16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if_b.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_b() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_b(), e.exp);
      end
    end
    push("rst_a",       0, 1'b0, 1'b0, pk(0, 0, 8'd0, 16'h0000));
    push("rst_a_hold",  3, 1'b0, 1'b0, pk(0, 0, 8'd0, 16'h0000));
    push("first_fetch", 1, 1'b1, 1'b0, pk(0, 0, 8'd1, 16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_arith();
    exp_t e;
    clear_mem();
    mem_a[0]  = ins(LDI, 15); mem_a[1]  = ins(STR, 0);  mem_a[2]  = ins(LDI, 1);
    mem_a[3]  = ins(ADD, 0);  mem_a[4]  = ins(JZ, 14);  mem_a[5]  = ins(JC, 14);
    mem_a[6]  = ins(LDI, 1);  mem_a[7]  = ins(STR, 1);  mem_a[8]  = ins(LDI, 0);
    mem_a[9]  = ins(SUB, 1);  mem_a[10] = ins(JZ, 0);   mem_a[11] = ins(JC, 13);
    mem_a[12] = ins(JC, 4);   mem_a[13] = ins(STR, 2);  mem_a[14] = ins(XOR, 2);
    mem_a[15] = ins(JZ, 12);
    do_reset(1'b1);
    push("add_acc",   8, 1'b1, 1'b0, pk(0, 0, 8'd4,  16'h0010));
    push("add_flags", 4, 1'b1, 1'b0, pk(0, 0, 8'd6,  16'h0010));
    push("sub_acc",   8, 1'b1, 1'b0, pk(0, 0, 8'd10, 16'h00FF));
    push("sub_z0",    2, 1'b1, 1'b0, pk(0, 0, 8'd11, 16'h00FF));
    push("sub_c1",    2, 1'b1, 1'b0, pk(0, 0, 8'd13, 16'h00FF));
    push("str_ff",    2, 1'b1, 1'b0, pk(0, 0, 8'd14, 16'h00FF));
    push("xor_acc",   2, 1'b1, 1'b0, pk(0, 0, 8'd15, 16'h0000));
    push("xor_z1",    2, 1'b1, 1'b0, pk(0, 0, 8'd12, 16'h0000));
    push("xor_c0",    2, 1'b1, 1'b0, pk(0, 0, 8'd13, 16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    clear_mem();
    mem_a[0]  = ins(LDI, 0); mem_a[1]  = ins(AND, 0); mem_a[2]  = ins(JZ, 7);
    mem_a[7]  = ins(LDI, 1); mem_a[8]  = ins(OR, 0);  mem_a[9]  = ins(JZ, 2);
    mem_a[10] = ins(SUB, 0); mem_a[11] = ins(JC, 3);
    do_reset(1'b1);
    push("jz_taken", 6, 1'b1, 1'b0, pk(0, 0, 8'd7,  16'h0000));
    push("jz_fall",  6, 1'b1, 1'b0, pk(0, 0, 8'd10, 16'h0001));
    push("jc_fall",  4, 1'b1, 1'b0, pk(0, 0, 8'd12, 16'h0001));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_call_ret();
    exp_t e;
    clear_mem();
    mem_a[2] = ins(CALL, 8); mem_a[8] = ins(RET, 0);
    mem_a[3] = ins(RET, 0);  mem_a[4] = ins(LDI, 7);
    do_reset(1'b1);
    push("call_pc",    6, 1'b1, 1'b0, pk(0, 0, 8'd8, 16'h0000));
    push("ret_pc",     2, 1'b1, 1'b0, pk(0, 0, 8'd3, 16'h0000));
    push("underflow",  2, 1'b1, 1'b0, pk(0, 1, 8'd4, 16'h0000));
    push("unf_frozen", 6, 1'b1, 1'b0, pk(0, 1, 8'd4, 16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_nested_fault();
    exp_t e;
    clear_mem();
    mem_a[0] = ins(CALL, 4); mem_a[4]  = ins(CALL, 8);
    mem_a[8] = ins(CALL, 12); mem_a[12] = ins(LDI, 3);
    mem_a[9] = ins(LDI, 7);
    do_reset(1'b1);
    push("call1",      2, 1'b1, 1'b0, pk(0, 0, 8'd4, 16'h0000));
    push("call2",      2, 1'b1, 1'b0, pk(0, 0, 8'd8, 16'h0000));
    push("overflow",   2, 1'b1, 1'b0, pk(0, 1, 8'd9, 16'h0000));
    push("ovf_frozen", 6, 1'b1, 1'b0, pk(0, 1, 8'd9, 16'h0000));
    push("fault_rst",  0, 1'b1, 1'b1, pk(0, 0, 8'd0, 16'h0000));
    push("fault_rerun", 2, 1'b1, 1'b0, pk(0, 0, 8'd4, 16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    clear_mem();
    mem_a[0] = ins(LDI, 5); mem_a[1] = ins(HLT, 0); mem_a[2] = ins(LDI, 9);
    do_reset(1'b1);
    push("halt",      4, 1'b1, 1'b0, pk(1, 0, 8'd2, 16'h0005));
    push("halt_hold", 6, 1'b1, 1'b0, pk(1, 0, 8'd2, 16'h0005));
    push("halt_rst",  0, 1'b1, 1'b1, pk(0, 0, 8'd0, 16'h0000));
    push("halt_rerun", 2, 1'b1, 1'b0, pk(0, 0, 8'd1, 16'h0005));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_run_hold();
    exp_t e;
    clear_mem();
    mem_a[0] = ins(LDI, 3);  mem_a[1] = ins(STR, 1);
    mem_a[2] = ins(LDI, 10); mem_a[3] = ins(ADD, 1);
    mem_a[4] = ins(LDI, 6);
    do_reset(1'b1);
    push("rh_ldi",    2, 1'b1, 1'b0, pk(0, 0, 8'd1, 16'h0003));
    push("rh_fetch",  1, 1'b1, 1'b0, pk(0, 0, 8'd2, 16'h0003));
    push("rh_hold_e", 5, 1'b0, 1'b0, pk(0, 0, 8'd2, 16'h0003));
    push("rh_exec",   1, 1'b1, 1'b0, pk(0, 0, 8'd2, 16'h0003));
    push("rh_add",    4, 1'b1, 1'b0, pk(0, 0, 8'd4, 16'h000D));
    push("rh_hold_f", 3, 1'b0, 1'b0, pk(0, 0, 8'd4, 16'h000D));
    push("rh_resume", 2, 1'b1, 1'b0, pk(0, 0, 8'd5, 16'h0006));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    clear_mem();
    do_reset(1'b1);
    push("wrap_15", 30, 1'b1, 1'b0, pk(0, 0, 8'd15, 16'h0000));
    push("wrap_0",   2, 1'b1, 1'b0, pk(0, 0, 8'd0,  16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_a.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_a() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_a(), e.exp);
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    clear_mem();
    mem_b[5]  = ins(LDI, 1); mem_b[6]  = ins(STR, 2); mem_b[7]  = ins(LDI, 0);
    mem_b[8]  = ins(SUB, 2); mem_b[9]  = ins(STR, 7); mem_b[10] = ins(LDI, 1);
    mem_b[11] = ins(ADD, 7); mem_b[12] = ins(JC, 15); mem_b[15] = ins(JZ, 3);
    do_reset(1'b1);
    push("w_sub", 8, 1'b1, 1'b0, pk(0, 0, 8'd9,  16'hFFFF));
    push("w_add", 6, 1'b1, 1'b0, pk(0, 0, 8'd12, 16'h0000));
    push("w_c1",  2, 1'b1, 1'b0, pk(0, 0, 8'd15, 16'h0000));
    push("w_z1",  2, 1'b1, 1'b0, pk(0, 0, 8'd3,  16'h0000));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) do_reset(e.run);
      if_b.Run = e.run;
      repeat (e.cyc) @(negedge clk);
      checks++;
      if (obs_b() !== e.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, obs_b(), e.exp);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    if_a.Run = 1'b1;
    if_b.Run = 1'b1;
    clear_mem();
    test_reset();
    test_arith();
    test_branch();
    test_call_ret();
    test_nested_fault();
    test_halt();
    test_run_hold();
    test_wrap();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/mcu_nbit_core.md
# mcu_nbit_core

Parametrised accumulator micro-controller core: the next generation of the 8-bit MCU, generalised in data width, program-counter width, register count and call depth. It adds subroutine CALL/RET with a hardware return stack, registered Z/C flags, a HALT state, a fault state and a run/hold input. Instruction memory stays external: the core drives `PC` and samples `Instr` combinationally in the same cycle. It sits at the MCU top level in place of the discrete PC/IR/FSM/ALU/accumulator/register-file assembly.

## Interface
- `DATA_W`, 8: accumulator, register and ALU width (≥4).
- `PC_W`, 8: program counter width.
- `OPR_W`, 4: instruction operand field width; instruction width is `4+OPR_W`.
- `NUM_REGS`, 4: register-file depth; power of two, ≤ 2**OPR_W.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `RESET_PC`, 0: PC value loaded at reset.
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-low; one clock, reset is synchronous and active-low.
- `Run`, in, 1: 1 = advance; 0 = hold all state.
- `Instr`, in, 4+OPR_W: instruction at `PC`; `[OPR_W+3:OPR_W]` = opcode, `[OPR_W-1:0]` = operand.
- `PC`, out, PC_W: current fetch address.
- `Acc`, out, DATA_W: accumulator value.
- `Halted`, out, 1: core is in HALT.
- `Fault`, out, 1: core is in FAULT (stack over/underflow).

## Operation
- Registered state: `PC`, `IR`, `Acc`, `R[NUM_REGS]`, `Z`, `C`, `SP` (0..STACK_DEPTH), return stack, FSM.
- FSM states: FETCH, EXEC, HALT, FAULT.
  - FETCH → EXEC: `IR<=Instr`, `PC<=PC+1` (mod 2**PC_W).
  - EXEC → FETCH, except HLT → HALT and stack error → FAULT.
  - HALT and FAULT are absorbing; only reset exits.
- `imm` = operand zero-extended to DATA_W (or PC_W). `r` = `operand[log2(NUM_REGS)-1:0]`.
- Opcodes:
  - 0 NOP.
  - 1 LDI: `Acc<=imm`.
  - 2 LDR: `Acc<=R[r]`.
  - 3 STR: `R[r]<=Acc`.
  - 4 ADD: `{C,Acc}<=Acc+R[r]`.
  - 5 SUB: `Acc<=Acc-R[r]`; `C<=1` on borrow (`Acc<R[r]` unsigned).
  - 6 AND, 7 OR, 8 XOR: `Acc<=Acc op R[r]`; `C<=0`.
  - 9 JMP: `PC<=imm`.
  - A JZ: `PC<=imm` if `Z`.
  - B JC: `PC<=imm` if `C`.
  - C CALL: `stack[SP]<=PC`, `SP<=SP+1`, `PC<=imm`.
  - D RET: `SP<=SP-1`, `PC<=stack[SP-1]`.
  - E HLT.
  - F reserved, executes as NOP.
- Flags:
  - `Z` and `C` are updated only by opcodes 4–8.
  - `Z<=(new Acc==0)`.
  - All other opcodes leave `Z` and `C` unchanged.
- Stack errors:
  - CALL with `SP==STACK_DEPTH`: overflow. No push, `PC` unchanged, → FAULT.
  - RET with `SP==0`: underflow. `PC` unchanged, → FAULT.
- PC wrap: FETCH at `2**PC_W-1` gives `PC=0`. Jump targets wider than PC_W are truncated.
- The pushed return address is the already-incremented `PC`, i.e. the next instruction.

## Timing
- Every instruction takes exactly 2 enabled cycles: FETCH then EXEC. There is no pipelining.
- All architectural updates land on the EXEC rising edge. `Acc`, `Z`, `C`, `Halted` and `Fault` are visible the following cycle.
- `Instr` must be valid in the FETCH cycle for the current `PC`. It is ignored in every other state.
- `Run=0`: no state changes, including FSM, PC, flags and registers. Run is re-sampled every edge, and the interrupted state resumes unchanged.
- Reset (`Reset=0` at an edge) overrides `Run` and any state, including mid-EXEC, HALT and FAULT. Reset values:
  - `PC=RESET_PC`
  - `Acc=0`, all `R=0`, `Z=0`, `C=0`, `SP=0`
  - stack contents don't-care
  - FSM = FETCH, `Halted=0`, `Fault=0`
- First fetch occurs on the first edge with `Reset=1`, `Run=1`.
- `Halted` and `Fault` are registered and asserted from the cycle after the HLT or faulting EXEC edge.

## Test plan
- Arithmetic and flags, DATA_W=8. Program:
  - `LDI 15; STR 0; LDI 1; ADD 0`, expect `Acc=0x10`, `C=0`, `Z=0`.
  - Extend to `LDI 1; STR 1; LDI 0; SUB 1`, expect `Acc=0xFF`, `C=1`, `Z=0`.
  - Then `XOR` with a register holding 0xFF, expect `Acc=0`, `Z=1`, `C=0`.
- Branches:
  - `LDI 0; AND 0; JZ 7`: `PC=7` after EXEC.
  - Same with `Z=0` falls through to `PC=3`.
  - JC is taken only after a borrow.
- Call/return, STACK_DEPTH=2:
  - CALL at PC 2 to 8, RET at 8: PC returns to 3, `SP` back to 0.
  - Three nested CALLs: the third sets `Fault=1`, `PC` frozen, and further `Instr` is ignored.
- Underflow and halt:
  - RET at `SP=0` sets `Fault=1`.
  - HLT sets `Halted=1` and the PC stops.
  - `Reset=0` for one edge clears both and `PC=RESET_PC`.
- Run/hold and wrap, PC_W=4:
  - Drop `Run` mid-instruction for 5 cycles: no state change, then the instruction completes identically.
  - NOP-filled memory: `PC` wraps 15→0.
- Parameter sweep: repeat the arithmetic test with DATA_W=16, NUM_REGS=8. The carry-out of `0xFFFF+1` gives `Acc=0`, `C=1`, `Z=1`.
